endp_flit_injector: RTL and testbench

- Endpoint-side transmitter that turns packet requests from a processing element into head/body/tail flits for one router local input port.
- Uses credit-based, per-VC flow control.
- Sits between an endpoint core and the chan_in_all entry of the NoC top for that endpoint ID.
- Consumes the credits the router returns on the matching chan_out_all entry.

---
 rtl/endp_flit_injector.sv | 222 ++++++++++++++++++++++
 tb/tb_endp_flit_injector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endp_flit_injector.sv
// endp_flit_injector
//   Endpoint-side transmitter. Turns packet requests from a processing element
//   into head/body/tail flits for one router local input port, using per-VC
//   credit-based flow control.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   pck_valid/ready   packet request handshake (dest, src, vc, len)
//   dat_valid/ready   body payload handshake (dat_in)
//   flit_wr/flit_out  registered one-cycle flit strobe and flit
//                     {head, tail, one-hot vc, payload}
//   credit_in         one returned credit per asserted bit per cycle
//   credit_err        sticky over-credit flag
//   busy              a packet is in progress
module endp_flit_injector #(
  parameter int V       = 4,
  parameter int B       = 4,
  parameter int EAw     = 8,
  parameter int Fpay    = 32,
  parameter int MAX_PCK = 16,
  parameter int Lw      = 5,
  localparam int VCW    = (V > 1) ? $clog2(V) : 1,
  localparam int CW     = $clog2(B + 1),
  localparam int FW     = Fpay + 2 + V
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pck_valid,
  output logic            pck_ready,
  input  logic [EAw-1:0]  pck_dest,
  input  logic [EAw-1:0]  pck_src,
  input  logic [VCW-1:0]  pck_vc,
  input  logic [Lw-1:0]   pck_len,
  input  logic            dat_valid,
  output logic            dat_ready,
  input  logic [Fpay-1:0] dat_in,
  output logic            flit_wr,
  output logic [FW-1:0]   flit_out,
  input  logic [V-1:0]    credit_in,
  output logic            credit_err,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [EAw-1:0]  dest_q, dest_d;
  logic [EAw-1:0]  src_q, src_d;
  logic [VCW-1:0]  vc_q, vc_d;
  logic [Lw-1:0]   rem_q, rem_d;     // flits still owed after the one being sent
  logic            busy_q, busy_d;
  logic            flit_wr_q;
  logic [FW-1:0]   flit_q, flit_d;
  logic [CW-1:0]   cred_q [V];
  logic [CW-1:0]   cred_d [V];
  logic            err_q, err_d;

  logic            issue_s;
  logic            has_cred_s;
  logic            dat_ready_s;
  logic [Lw-1:0]   len_eff_s;
  logic [V-1:0]    vc_oh_s;
  logic [V-1:0]    dec_s;
  logic [Fpay-1:0] head_pay_s;

  assign has_cred_s = (cred_q[vc_q] != {CW{1'b0}});
  assign vc_oh_s    = {{(V-1){1'b0}}, 1'b1} << vc_q;

  // Normalise the requested length: 0 means 1, oversize is clamped.
  always_comb begin
    if (pck_len == {Lw{1'b0}}) begin
      len_eff_s = Lw'(1);
    end else if (pck_len > Lw'(MAX_PCK)) begin
      len_eff_s = Lw'(MAX_PCK);
    end else begin
      len_eff_s = pck_len;
    end
  end

  // Head payload: src in the low field, dest above it, zeros elsewhere.
  always_comb begin
    head_pay_s              = {Fpay{1'b0}};
    head_pay_s[2*EAw-1:0]   = {dest_q, src_q};
  end

  // Packet FSM: next state, latched header fields and the flit to emit.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    src_d       = src_q;
    vc_d        = vc_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    flit_d      = flit_q;
    issue_s     = 1'b0;
    dat_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pck_valid) begin
          dest_d  = pck_dest;
          src_d   = pck_src;
          vc_d    = pck_vc;
          rem_d   = len_eff_s - Lw'(1);
          busy_d  = 1'b1;
          state_d = ST_HEAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEAD: begin
        if (has_cred_s) begin
          issue_s = 1'b1;
          flit_d  = {1'b1, (rem_q == {Lw{1'b0}}), vc_oh_s, head_pay_s};
          if (rem_q == {Lw{1'b0}}) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BODY;
          end
        end else begin
          state_d = ST_HEAD;
        end
      end
      ST_BODY: begin
        dat_ready_s = has_cred_s;
        if (dat_valid && has_cred_s) begin
          issue_s = 1'b1;
          flit_d  = {1'b0, (rem_q == Lw'(1)), vc_oh_s, dat_in};
          rem_d   = rem_q - Lw'(1);
          if (rem_q == Lw'(1)) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BODY;
          end
        end else begin
          state_d = ST_BODY;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Which VC loses a credit this cycle because a flit is being issued.
  always_comb begin
    dec_s = {V{1'b0}};
    if (issue_s) begin
      dec_s = vc_oh_s;
    end else begin
      dec_s = {V{1'b0}};
    end
  end

  // Per-VC credit counters; a return while already full is flagged and dropped.
  always_comb begin
    err_d = err_q;
    for (int v = 0; v < V; v++) begin
      cred_d[v] = cred_q[v];
      if (credit_in[v] && (cred_q[v] == CW'(B))) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
      if (credit_in[v] && dec_s[v]) begin
        cred_d[v] = cred_q[v];
      end else if (dec_s[v]) begin
        cred_d[v] = cred_q[v] - CW'(1);
      end else if (credit_in[v] && (cred_q[v] != CW'(B))) begin
        cred_d[v] = cred_q[v] + CW'(1);
      end else begin
        cred_d[v] = cred_q[v];
      end
    end
  end

  // State, header, flit and credit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      dest_q    <= {EAw{1'b0}};
      src_q     <= {EAw{1'b0}};
      vc_q      <= {VCW{1'b0}};
      rem_q     <= {Lw{1'b0}};
      busy_q    <= 1'b0;
      flit_wr_q <= 1'b0;
      flit_q    <= {FW{1'b0}};
      err_q     <= 1'b0;
      for (int v = 0; v < V; v++) begin
        cred_q[v] <= CW'(B);
      end
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      vc_q      <= vc_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      flit_wr_q <= issue_s;
      flit_q    <= flit_d;
      err_q     <= err_d;
      for (int v = 0; v < V; v++) begin
        cred_q[v] <= cred_d[v];
      end
    end
  end

  // Requests are refused while reset is held, even though the FSM sits in IDLE.
  assign pck_ready  = (state_q == ST_IDLE) & reset;
  assign dat_ready  = dat_ready_s;
  assign flit_wr    = flit_wr_q;
  assign flit_out   = flit_q;
  assign credit_err = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_endp_flit_injector.sv
module tb_endp_flit_injector;
  localparam int V = 4, B = 4, EAw = 8, Fpay = 32, MAX_PCK = 16, Lw = 5;
  localparam int FW = Fpay + 2 + V;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            pck_valid, pck_ready, dat_valid, dat_ready, flit_wr, credit_err, busy;
  logic [EAw-1:0]  pck_dest, pck_src;
  logic [1:0]      pck_vc;
  logic [Lw-1:0]   pck_len;
  logic [Fpay-1:0] dat_in;
  logic [FW-1:0]   flit_out;
  logic [V-1:0]    credit_in;

  endp_flit_injector dut (
    .clk(clk), .reset(reset),
    .pck_valid(pck_valid), .pck_ready(pck_ready),
    .pck_dest(pck_dest), .pck_src(pck_src), .pck_vc(pck_vc), .pck_len(pck_len),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
    .flit_wr(flit_wr), .flit_out(flit_out),
    .credit_in(credit_in), .credit_err(credit_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [FW-1:0] exp_q[$];
  int out_cnt[V];          // flits sitting in the router buffer per VC
  bit exp_err = 1'b0;
  int flit_cnt = 0, last_flit_cyc = 0, cyc = 0, acc_cyc = 0;
  logic [V-1:0] cred_sampled = '0, man_cred = '0;
  bit cred_auto = 1'b0, abort_pkt = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    cred_sampled <= credit_in;
  end

  // Monitor: scoreboard pop, router buffer model, sticky error model, credit driver.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      for (int v = 0; v < V; v++) out_cnt[v] = 0;
      exp_err = 1'b0;
    end else begin
      if (flit_wr) begin
        flit_cnt++;
        last_flit_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_flit: got %0h expected none", flit_out);
        end else begin
          chk("flit", flit_out, exp_q.pop_front());
        end
      end
      for (int v = 0; v < V; v++) begin
        int pre;
        int f;
        pre = out_cnt[v];
        f = (flit_wr && flit_out[Fpay+v]) ? 1 : 0;
        if (f == 1) chk("flit_had_credit", (pre < B) ? 1 : 0, 1);
        if (cred_sampled[v] && pre == 0) exp_err = 1'b1;
        out_cnt[v] = pre + f - (cred_sampled[v] ? 1 : 0);
        if (out_cnt[v] < 0) out_cnt[v] = 0;
      end
      chk("credit_err", credit_err, exp_err);
    end
    if (cred_auto && reset) begin
      for (int v = 0; v < V; v++) credit_in[v] = (out_cnt[v] > 0) && ($urandom_range(1) == 1);
    end else begin
      credit_in = man_cred;
    end
  end

  task automatic send_pkt(input logic [7:0] d, input logic [7:0] s, input logic [1:0] vc,
                          input logic [4:0] len, input int bubble);
    int le, idx, guard;
    logic [31:0] pay[$];
    logic [V-1:0] oh;
    le = (len == 0) ? 1 : ((len > MAX_PCK) ? MAX_PCK : int'(len));
    oh = 4'b0001 << vc;
    exp_q.push_back({1'b1, (le == 1), oh, 16'h0000, d, s});
    for (int i = 1; i < le; i++) begin
      logic [31:0] p;
      p = $urandom;
      pay.push_back(p);
      exp_q.push_back({1'b0, (i == le - 1), oh, p});
    end
    guard = 0;
    @(negedge clk);
    while (!pck_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!pck_ready) begin
      total++; bad++;
      $display("FAIL pck_ready_timeout: got 0 expected 1");
      return;
    end
    pck_valid = 1'b1; pck_dest = d; pck_src = s; pck_vc = vc; pck_len = len;
    @(posedge clk); #1;
    acc_cyc = cyc;
    pck_valid = 1'b0;
    idx = 0; guard = 0;
    while (idx < le - 1) begin
      @(negedge clk);
      if (abort_pkt) begin
        dat_valid = 1'b0;
        return;
      end
      dat_valid = ($urandom_range(99) >= bubble);
      dat_in = pay[idx];
      #1;
      if (dat_valid && dat_ready) idx++;
      guard++;
      if (guard > 600) begin
        total++; bad++;
        $display("FAIL dat_timeout: got %0d flits expected %0d", idx + 1, le);
        dat_valid = 1'b0;
        return;
      end
    end
    if (le > 1) begin
      @(posedge clk); #1;
      dat_valid = 1'b0;
    end
  endtask

  task automatic pulse_cred(input int v);
    @(negedge clk); #1 man_cred[v] = 1'b1;
    @(negedge clk); #1 man_cred[v] = 1'b0;
  endtask

  task automatic restore_credits();
    int g;
    bool_wait: begin
      cred_auto = 1'b1;
      g = 0;
      forever begin
        int sum;
        @(negedge clk); #1;
        sum = 0;
        for (int v = 0; v < V; v++) sum += out_cnt[v];
        if ((sum == 0 && !busy) || g > 200) break;
        g++;
      end
      chk("restore_timeout", (g > 200) ? 1 : 0, 0);
      cred_auto = 1'b0;
    end
  endtask

  initial begin
    int base, g;
    pck_valid = 1'b0; pck_dest = '0; pck_src = '0; pck_vc = '0; pck_len = '0;
    dat_valid = 1'b0; dat_in = '0; credit_in = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_flit_wr", flit_wr, 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dat_ready", dat_ready, 0);
    chk("rst_pck_ready", pck_ready, 0);
    @(negedge clk); reset = 1'b1;

    // single-flit packet
    base = flit_cnt;
    send_pkt(8'h05, 8'h03, 2'd2, 5'd1, 0);
    chk("single_busy", busy, 1);
    chk("single_pck_ready_low", pck_ready, 0);
    @(posedge clk); #1;
    chk("single_flit_wr", flit_wr, 1);
    chk("single_busy_clear", busy, 0);
    chk("single_pck_ready_back", pck_ready, 1);
    @(negedge clk); #1;
    chk("single_latency", last_flit_cyc - acc_cyc, 1);
    chk("single_count", flit_cnt - base, 1);

    // len=4 on vc0, data always valid
    base = flit_cnt;
    send_pkt(8'h11, 8'h22, 2'd0, 5'd4, 0);
    @(negedge clk); #1;
    chk("len4_count", flit_cnt - base, 4);
    chk("len4_span", last_flit_cyc - acc_cyc, 4);
    chk("len4_busy", busy, 0);

    // credit stall on vc1
    base = flit_cnt;
    fork
      send_pkt(8'h01, 8'h02, 2'd1, 5'd6, 0);
      begin
        g = 0;
        while (flit_cnt - base < 4 && g < 50) begin @(negedge clk); #1; g++; end
        repeat (3) @(negedge clk); #1;
        chk("stall_count", flit_cnt - base, 4);
        chk("stall_dat_ready", dat_ready, 0);
        chk("stall_flit_wr", flit_wr, 0);
        pulse_cred(1);
        repeat (3) @(negedge clk); #1;
        chk("stall_resume1", flit_cnt - base, 5);
        pulse_cred(1);
        repeat (3) @(negedge clk); #1;
        chk("stall_resume2", flit_cnt - base, 6);
        chk("stall_busy", busy, 0);
      end
    join
    restore_credits();

    // simultaneous issue and return on vc3
    fork
      send_pkt(8'h33, 8'h44, 2'd3, 5'd8, 0);
      begin
        g = 0;
        @(posedge clk); #1;
        while (!flit_wr && g < 50) begin @(posedge clk); #1; g++; end
        man_cred[3] = 1'b1;
        for (int i = 0; i < 7; i++) begin
          @(posedge clk); #1;
          chk("simul_no_stall", flit_wr, 1);
        end
        man_cred[3] = 1'b0;
      end
    join
    chk("simul_no_err", credit_err, 0);
    restore_credits();

    // over-credit on vc3 with full counter
    pulse_cred(3);
    repeat (2) @(negedge clk); #1;
    chk("overcredit_err", credit_err, 1);
    repeat (5) @(negedge clk); #1;
    chk("overcredit_sticky", credit_err, 1);
    base = flit_cnt;
    fork
      send_pkt(8'h55, 8'h66, 2'd3, 5'd5, 0);
      begin
        repeat (10) @(negedge clk); #1;
        chk("overcredit_cap", flit_cnt - base, 4);
        cred_auto = 1'b1;
      end
    join
    restore_credits();

    // reset in the middle of a packet
    fork
      send_pkt(8'h77, 8'h88, 2'd0, 5'd8, 0);
      begin
        g = 0;
        @(posedge clk); #1;
        while (!flit_wr && g < 50) begin @(posedge clk); #1; g++; end
        #1 reset = 1'b0; abort_pkt = 1'b1;
        #1;
        chk("midrst_flit_wr", flit_wr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pck_ready", pck_ready, 0);
        chk("midrst_credit_err", credit_err, 0);
      end
    join
    repeat (3) @(negedge clk);
    reset = 1'b1; abort_pkt = 1'b0;
    base = flit_cnt;
    send_pkt(8'h99, 8'hAA, 2'd0, 5'd4, 0);
    @(negedge clk); #1;
    chk("postrst_count", flit_cnt - base, 4);
    chk("postrst_span", last_flit_cyc - acc_cyc, 4);

    // randomized traffic with credit returns and data bubbles
    cred_auto = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send_pkt(8'($urandom), 8'($urandom), 2'($urandom_range(3)), 5'($urandom_range(20)), 30);
    end
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 500) begin @(negedge clk); #1; g++; end
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
